// File: rtl/hil_mux_stim_rx.sv
// Host-driven stimulus stage for the 4:1 mux under test: receives 8-bit command
// frames over a 3-wire GPIO serial link, drives the mux, samples Y and returns it.
module hil_mux_stim_rx #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rpi_sclk,
  input  logic       rpi_mosi,
  input  logic       rpi_cs_n,
  output logic       rpi_miso,
  output logic [3:0] dut_i,
  output logic [1:0] dut_s,
  input  logic       dut_y,
  output logic       result_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DISCARD
  } state_t;

  localparam logic [1:0] CMD_APPLY   = 2'b01;
  localparam logic [1:0] CMD_CLR_ERR = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  logic [2:0] async_in;
  logic [2:0] sync_out;

  assign async_in = {rpi_cs_n, rpi_mosi, rpi_sclk};

  // cs_n synchronizer resets to "asserted" so a frame already in progress at
  // reset release never produces a falling edge; the bus is ignored until cs_n rises.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
      end
      assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sclk_s, mosi_s, cs_s;
  assign sclk_s = sync_out[0];
  assign mosi_s = sync_out[1];
  assign cs_s   = sync_out[2];

  state_t     state_reg;
  logic [7:0] rx_reg;
  logic [7:0] tx_reg;
  logic [7:0] resp_reg;
  logic [7:0] settle_cnt_reg;
  logic [3:0] bit_cnt_reg;
  logic       sticky_reg;
  logic       sclk_prev_reg;
  logic       cs_prev_reg;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, frame_ok;
  assign sclk_rise = sclk_s & ~sclk_prev_reg & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_reg & ~cs_s;
  assign cs_fall   = cs_prev_reg & ~cs_s;
  assign cs_rise   = ~cs_prev_reg & cs_s;
  assign frame_ok  = (bit_cnt_reg == 4'd8) && (rx_reg[7:6] != CMD_ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rx_reg         <= '0;
      tx_reg         <= '0;
      resp_reg       <= '0;
      settle_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      sticky_reg     <= 1'b0;
      sclk_prev_reg  <= 1'b0;
      cs_prev_reg    <= 1'b0;
      rpi_miso       <= 1'b0;
      dut_i          <= '0;
      dut_s          <= '0;
      result_valid   <= 1'b0;
      frame_err      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      result_valid  <= 1'b0;
      frame_err     <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          rpi_miso <= 1'b0;
          if (cs_fall) begin
            state_reg   <= ST_RECV;
            bit_cnt_reg <= '0;
            tx_reg      <= resp_reg;
            rpi_miso    <= resp_reg[7];
          end
        end

        ST_RECV: begin
          if (cs_rise) begin
            rpi_miso  <= 1'b0;
            state_reg <= ST_IDLE;
            if (!frame_ok) begin
              frame_err   <= 1'b1;
              sticky_reg  <= 1'b1;
              resp_reg[6] <= 1'b1;
            end else begin
              case (rx_reg[7:6])
                CMD_APPLY: begin
                  dut_s          <= rx_reg[5:4];
                  dut_i          <= rx_reg[3:0];
                  settle_cnt_reg <= SETTLE_INIT;
                  busy           <= 1'b1;
                  state_reg      <= ST_SETTLE;
                end
                CMD_CLR_ERR: begin
                  sticky_reg  <= 1'b0;
                  resp_reg[6] <= 1'b0;
                end
                default: resp_reg[6] <= sticky_reg;
              endcase
            end
          end else begin
            if (sclk_rise) begin
              rx_reg <= {rx_reg[6:0], mosi_s};
              if (bit_cnt_reg != 4'd15) bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            // Zero-fill means the line drops to 0 once all 8 response bits are out.
            if (sclk_fall) begin
              rpi_miso <= tx_reg[6];
              tx_reg   <= {tx_reg[6:0], 1'b0};
            end
          end
        end

        ST_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg - 8'd1;
          if (settle_cnt_reg <= 8'd1) state_reg <= ST_SAMPLE;
        end

        ST_SAMPLE: begin
          resp_reg     <= {dut_y, sticky_reg, dut_s, dut_i};
          result_valid <= 1'b1;
          busy         <= 1'b0;
          // A frame that started while busy cannot be received cleanly: drop it.
          state_reg    <= cs_s ? ST_IDLE : ST_DISCARD;
        end

        ST_DISCARD: begin
          if (cs_s) begin
            frame_err   <= 1'b1;
            sticky_reg  <= 1'b1;
            resp_reg[6] <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hil_mux_stim_rx.sv
// Scoreboard bench for hil_mux_stim_rx: directed frames push expected MISO bytes,
// results and frame errors into queues; monitors pop and compare as the DUT responds.
module tb_hil_mux_stim_rx;

  localparam int SETTLE = 20;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       rpi_sclk = 1'b0;
  logic       rpi_mosi = 1'b0;
  logic       rpi_cs_n = 1'b1;
  logic       rpi_miso;
  logic [3:0] dut_i;
  logic [1:0] dut_s;
  logic       dut_y;
  logic       result_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] miso_q[$];
  logic [5:0] result_q[$];
  logic [5:0] err_q[$];

  // Ideal 4:1 mux as the device under stimulus
  assign dut_y = dut_i[dut_s];

  always #5 clk = ~clk;

  hil_mux_stim_rx #(
    .SETTLE_CYCLES(SETTLE),
    .SYNC_STAGES  (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rpi_sclk    (rpi_sclk),
    .rpi_mosi    (rpi_mosi),
    .rpi_cs_n    (rpi_cs_n),
    .rpi_miso    (rpi_miso),
    .dut_i       (dut_i),
    .dut_s       (dut_s),
    .dut_y       (dut_y),
    .result_valid(result_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, int'({rpi_miso, dut_i, dut_s, result_valid, frame_err, busy}), 0);
  endtask

  // MISO monitor: samples the response bit on each sclk rise, as the host does
  initial begin : miso_mon
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    int         nb;
    bit         active;
    rx_byte = '0;
    nb      = 0;
    active  = 1'b0;
    forever begin
      @(posedge rpi_sclk or posedge rpi_cs_n or negedge rpi_cs_n or negedge rst_n);
      if (!rst_n) begin
        nb      = 0;
        rx_byte = '0;
      end else if (!rpi_cs_n && !active) begin
        active  = 1'b1;
        nb      = 0;
        rx_byte = '0;
      end else if (!rpi_cs_n && rpi_sclk) begin
        if (nb < 8) rx_byte[7-nb] = rpi_miso;
        nb++;
      end else if (rpi_cs_n && active) begin
        active = 1'b0;
        if (miso_q.size() == 0) begin
          check("miso_unexpected_frame", 1, 0);
        end else begin
          exp_b = miso_q.pop_front();
          $display("[%0t] frame end: miso byte 0x%02h, expected 0x%02h", $time, rx_byte, exp_b);
          check("miso_byte", int'(rx_byte), int'(exp_b));
        end
      end
    end
  end

  // Result / error monitor, sampled on the falling clock edge
  initial begin : out_mon
    int         cyc;
    int         change_cyc;
    logic [5:0] last_v;
    logic [5:0] exp_v;
    cyc        = 0;
    change_cyc = 0;
    last_v     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if ({dut_s, dut_i} != last_v) begin
        last_v     = {dut_s, dut_i};
        change_cyc = cyc;
      end
      if (result_valid) begin
        if (result_q.size() == 0) begin
          check("result_unexpected", 1, 0);
        end else begin
          exp_v = result_q.pop_front();
          $display("[%0t] result_valid: s/i=0x%02h, latency=%0d", $time, {dut_s, dut_i}, cyc - change_cyc);
          check("result_dut", int'({dut_s, dut_i}), int'(exp_v));
          check("result_latency", cyc - change_cyc, SETTLE + 1);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          check("frame_err_unexpected", 1, 0);
        end else begin
          exp_v = err_q.pop_front();
          $display("[%0t] frame_err: s/i=0x%02h held", $time, {dut_s, dut_i});
          check("err_dut_hold", int'({dut_s, dut_i}), int'(exp_v));
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rpi_mosi = b;
    clk_wait(8);
    rpi_sclk = 1'b1;
    clk_wait(8);
    rpi_sclk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    rpi_cs_n = 1'b0;
    clk_wait(8);
  endtask

  task automatic cs_high();
    clk_wait(8);
    rpi_cs_n = 1'b1;
    rpi_mosi = 1'b0;
    clk_wait(4);
  endtask

  task automatic frame(input logic [15:0] vec, input int nbits, input logic [7:0] exp_miso);
    miso_q.push_back(exp_miso);
    cs_low();
    for (int k = 0; k < nbits; k++) send_bit(vec[15-k]);
    cs_high();
  endtask

  task automatic wait_idle();
    int n = 0;
    clk_wait(4);
    while (busy && n < 200) begin
      clk_wait(1);
      n++;
    end
    check("busy_clear", int'(busy), 0);
    clk_wait(6);
  endtask

  task automatic nop(input logic [7:0] exp_miso);
    frame({8'h00, 8'h00}, 8, exp_miso);
    wait_idle();
  endtask

  task automatic clr_err(input logic [7:0] exp_miso);
    frame({8'h80, 8'h00}, 8, exp_miso);
    wait_idle();
  endtask

  task automatic apply(input logic [7:0] b, input logic [7:0] exp_miso, input logic [5:0] exp_res);
    result_q.push_back(exp_res);
    frame({b, 8'h00}, 8, exp_miso);
    wait_idle();
  endtask

  task automatic bad_frame(input logic [15:0] vec, input int nbits, input logic [7:0] exp_miso,
                           input logic [5:0] hold);
    err_q.push_back(hold);
    frame(vec, nbits, exp_miso);
    wait_idle();
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stim
    #2 rst_n = 1'b0;
    clk_wait(3);
    check_zero("reset_state");
    rst_n = 1'b1;
    clk_wait(5);
    check_zero("after_release");

    // Basic APPLY and readback across all select values
    apply(8'h4A, 8'h00, 6'h0A);
    nop(8'h0A);
    apply(8'h5A, 8'h0A, 6'h1A);
    nop(8'h9A);
    apply(8'h6A, 8'h9A, 6'h2A);
    nop(8'h2A);
    apply(8'h7A, 8'h2A, 6'h3A);
    nop(8'hBA);

    // Short frame sets sticky, CLR_ERR clears it
    bad_frame({8'h4F, 8'h00}, 5, 8'hB8, 6'h3A);
    nop(8'hFA);
    clr_err(8'hFA);
    nop(8'hBA);

    // Illegal command and a 9-bit frame
    bad_frame({8'hC5, 8'h00}, 8, 8'hBA, 6'h3A);
    nop(8'hFA);
    clr_err(8'hFA);
    bad_frame({8'h41, 1'b1, 7'h00}, 9, 8'hBA, 6'h3A);
    nop(8'hFA);
    clr_err(8'hFA);

    // Overrun: new frame while the APPLY is still settling
    result_q.push_back(6'h01);
    frame({8'h41, 8'h00}, 8, 8'hBA);
    err_q.push_back(6'h01);
    frame({8'h00, 8'h00}, 8, 8'h00);
    wait_idle();
    nop(8'hC1);
    clr_err(8'hC1);

    // Reset during SETTLE
    frame({8'h7F, 8'h00}, 8, 8'h81);
    clk_wait(6);
    check("busy_before_reset", int'(busy), 1);
    check("dut_before_reset", int'({dut_s, dut_i}), 'h3F);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_settle");
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(SETTLE + 10);
    nop(8'h00);

    // Reset during RECV with cs_n held low through release
    miso_q.push_back(8'h00);
    cs_low();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_recv");
    clk_wait(3);
    rst_n = 1'b1;
    repeat (5) send_bit(1'b1);
    cs_high();
    clk_wait(SETTLE + 10);
    check("dut_after_ignored_frame", int'({dut_s, dut_i}), 0);
    check("busy_after_ignored_frame", int'(busy), 0);
    nop(8'h00);
    apply(8'h43, 8'h00, 6'h03);
    nop(8'h83);

    clk_wait(20);
    check("miso_queue_drained", miso_q.size(), 0);
    check("result_queue_drained", result_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hil_mux_stim_rx.md
Name: hil_mux_stim_rx

Overview:
- Upstream stimulus stage for the 4:1 mux DUT in the RPi-FPGA HIL verifier.
- Receives 8-bit command frames from the Raspberry Pi over a 3-wire GPIO serial link (SCLK/MOSI/CS_N), drives the mux data/select inputs, waits a settle time, samples the mux output, and returns a response byte on MISO during the next frame.
- Replaces the fixed testbench stimulus with host-driven hardware vectors.

Parameters:
- SETTLE_CYCLES, 4, clk cycles between DUT input update and sampling of dut_y (legal range 1..255).
- SYNC_STAGES, 2, synchronizer flops on rpi_sclk, rpi_mosi and rpi_cs_n (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rpi_sclk  input  1  serial clock from RPi, asynchronous to clk.
- rpi_mosi  input  1  serial data from RPi, MSB first, sampled on sclk rising edge.
- rpi_cs_n  input  1  frame enable from RPi, active low.
- rpi_miso  output  1  response bit to RPi; changes on sclk falling edge.
- dut_i  output  4  mux data inputs I.
- dut_s  output  2  mux select S.
- dut_y  input  1  mux output Y.
- result_valid  output  1  one-cycle pulse when dut_y has been captured.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- busy  output  1  high in SETTLE and SAMPLE states.

Behaviour:
- Reset (async assert, sync release): dut_i=0, dut_s=0, rpi_miso=0, result_valid=0, frame_err=0, busy=0, response register=0x00, sticky error=0, state=IDLE, bit counter=0.
- All RPi inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals. clk must be at least 8x the sclk frequency.
- Frame format (MSB first) is cmd[7:6], s[5:4], i[3:0].
  - cmd 00: NOP/readback.
  - cmd 01: APPLY.
  - cmd 10: CLR_ERR.
  - cmd 11: illegal.
- States:
  - IDLE: on synced cs_n falling edge, go to RECV, clear bit counter, load shift-out register from response register, and drive rpi_miso = response[7].
  - RECV: on each synced sclk rising edge, shift mosi into rx register and increment bit counter (saturating at 15). On each sclk falling edge, shift the next response bit onto rpi_miso; after 8 bits, drive 0. On cs_n rising edge, evaluate the frame:
    - bit count != 8, or cmd=11: pulse frame_err, set sticky, go to IDLE, no DUT change.
    - cmd 00: go to IDLE.
    - cmd 10: clear sticky, go to IDLE.
    - cmd 01: on the next clk, dut_s<=s and dut_i<=i; go to SETTLE with counter = SETTLE_CYCLES.
  - SETTLE: decrement counter; when it reaches 0, go to SAMPLE.
  - SAMPLE (one cycle): response <= {dut_y, sticky, dut_s, dut_i}; pulse result_valid; go to IDLE.
- Total latency from the DUT update cycle to the result_valid pulse is SETTLE_CYCLES+1 clk.
- Response register update rules:
  - cmd 00, CLR_ERR and error frames: bit6 is refreshed to the current sticky value; bits 7 and 5:0 are kept.
  - APPLY: the full byte is refreshed in SAMPLE.
- Overrun: a cs_n falling edge during SETTLE/SAMPLE is accepted into RECV only after returning to IDLE. If cs_n is already low on entry to IDLE, that frame is discarded: wait for cs_n high, then pulse frame_err and set sticky.
- sclk edges while cs_n is high are ignored.
- rpi_miso is 0 whenever cs_n is high.
- Reset mid-frame or mid-settle: everything returns to reset values and the partial frame is discarded. If cs_n is low at reset release, ignore the bus until cs_n is seen high.
- dut_i and dut_s hold their value until the next valid APPLY; they are never glitched by NOP or error frames.

Test Plan:
- Reset then frame 0x4A (APPLY, S=00, I=1010) -> dut_i=4'hA and dut_s=0 one clk after cs_n rise is detected. result_valid pulses SETTLE_CYCLES+1 later. Next NOP frame returns MISO byte 0x0A (Y=0).
- Frames 0x5A, 0x6A, 0x7A, each followed by a NOP -> responses 0x9A, 0x2A, 0xBA (Y=1,0,1 for S=01,10,11). dut_y sampled exactly after the settle count.
- Short frame (5 bits, then cs_n high) -> frame_err pulse, dut_i/dut_s unchanged. Next NOP returns bit6=1. Frame 0x80 (CLR_ERR) then NOP -> bit6=0.
- Frame 0xC5 (illegal cmd) and a 9-bit frame -> each gives a frame_err pulse, no DUT update, sticky set.
- Start a new frame while busy (SETTLE_CYCLES=20) -> frame discarded, frame_err pulse. The in-flight APPLY still completes with a result_valid pulse.
- Assert rst_n low mid-SETTLE and mid-RECV -> all outputs return to 0 immediately. With cs_n held low through reset release, no frame is accepted until cs_n rises.
